alu_share_ctrl: RTL and testbench



---
 rtl/alu_share_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_share_ctrl
//  Purpose  : Time-shares the combinational execute-stage ALU between the
//             integer-execute port (0) and the branch/address port (1).
//             One operation in flight at a time: IDLE -> EXEC -> RESP.
//             Operands are registered at the request handshake and the ALU
//             result is captured and held until the owning port accepts it.
//  Config   : `define ALU_RR_ARB_EN for round-robin arbitration between the
//             two ports; otherwise port 0 has fixed priority.
//  Revision : 1.0  initial release
// ============================================================================
module alu_share_ctrl #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    // request side
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OPW-1:0]   req_op0,
    input  logic [OPW-1:0]   req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_b1,
    // response side
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err,
    // ALU connection
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_ina,
    output logic [WIDTH-1:0] alu_inb,
    input  logic [WIDTH-1:0] alu_out
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    // Opcodes 0 .. c_NUM_LEGAL_OPS-1 are executed; anything above is rejected.
    localparam int c_NUM_LEGAL_OPS = 10;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_owner;
    logic [OPW-1:0]   r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_zero;
    logic             r_rsp_err;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic [1:0]       w_grant;
    logic             w_accept;

`ifdef ALU_RR_ARB_EN
    // Port holding priority when both request together.
    logic             r_rr_ptr;

    // Round-robin grant: a lone requester always wins, ties go to the pointer.
    always_comb begin
        w_grant = 2'b00;
        if (r_state == c_IDLE) begin
            case (req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_rr_ptr ? 2'b10 : 2'b01;
                default: w_grant = 2'b00;
            endcase
        end
    end

    // After every grant the other port gets priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= 1'b0;
        end else if (w_accept) begin
            r_rr_ptr <= w_grant[0];
        end
    end
`else
    // Fixed-priority grant: port 0 always wins, port 1 only when port 0 idle.
    always_comb begin
        w_grant = 2'b00;
        if (r_state == c_IDLE) begin
            if (req_valid[0]) begin
                w_grant = 2'b01;
            end else if (req_valid[1]) begin
                w_grant = 2'b10;
            end
        end
    end
`endif

    assign w_accept  = |w_grant;
    assign req_ready = w_grant;

    // ------------------------------------------------------------------------
    // Selected request and opcode legality
    // ------------------------------------------------------------------------
    logic [OPW-1:0]   w_sel_op;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic             w_sel_legal;
    logic             w_owner_ack;
    logic             w_alu_zero;

    assign w_sel_op    = w_grant[1] ? req_op1 : req_op0;
    assign w_sel_a     = w_grant[1] ? req_a1  : req_a0;
    assign w_sel_b     = w_grant[1] ? req_b1  : req_b0;
    assign w_sel_legal = (int'(w_sel_op) < c_NUM_LEGAL_OPS);

    // Only the owner's acknowledge can retire a response.
    assign w_owner_ack = rsp_ready[r_owner];
    assign w_alu_zero  = (alu_out == '0);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // Next-state: illegal ops bypass EXEC since there is nothing to compute.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_sel_legal ? c_EXEC : c_RESP;
                end
            end
            c_EXEC: begin
                w_state_nxt = c_RESP;
            end
            c_RESP: begin
                if (w_owner_ack) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Remember which port owns the operation for response routing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner <= 1'b0;
        end else if (w_accept) begin
            r_owner <= w_grant[1];
        end
    end

    // ALU operand registers: loaded only for legal ops so the ALU inputs
    // stay quiet (no toggling) outside of real work.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op <= '0;
            r_a  <= '0;
            r_b  <= '0;
        end else if (w_accept && w_sel_legal) begin
            r_op <= w_sel_op;
            r_a  <= w_sel_a;
            r_b  <= w_sel_b;
        end
    end

    // Response registers: ALU result captured at the end of EXEC, or a
    // forced zero/error result when an illegal opcode is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_data <= '0;
            r_rsp_zero <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else if (r_state == c_IDLE && w_accept && !w_sel_legal) begin
            r_rsp_data <= '0;
            r_rsp_zero <= 1'b1;
            r_rsp_err  <= 1'b1;
        end else if (r_state == c_EXEC) begin
            r_rsp_data <= alu_out;
            r_rsp_zero <= w_alu_zero;
            r_rsp_err  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rsp_valid
            assign rsp_valid[gi] = (r_state == c_RESP) && (int'(r_owner) == gi);
        end
    endgenerate

    assign rsp_data = r_rsp_data;
    assign rsp_zero = r_rsp_zero;
    assign rsp_err  = r_rsp_err;

    assign alu_op   = r_op;
    assign alu_ina  = r_a;
    assign alu_inb  = r_b;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_share_ctrl
//  Purpose  : Self-checking bench for alu_share_ctrl. A behavioural ALU
//             closes the loop on alu_out; expected responses are queued at
//             each request handshake and compared when the DUT responds.
//             Honours `define ALU_RR_ARB_EN for the grant-order expectation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_share_ctrl;

    localparam int WIDTH = 32;
    localparam int OPW   = 4;

    logic             clk;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [OPW-1:0]   req_op0, req_op1;
    logic [WIDTH-1:0] req_a0, req_a1, req_b0, req_b1;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic             rsp_err;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_ina, alu_inb, alu_out;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        zero;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks;
    int          n_fail;
    int          cyc;
    bit          exp_ptr;
    logic [3:0]  last_legal_op;

    alu_share_ctrl #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op0   (req_op0),
        .req_op1   (req_op1),
        .req_a0    (req_a0),
        .req_a1    (req_a1),
        .req_b0    (req_b0),
        .req_b1    (req_b1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err),
        .alu_op    (alu_op),
        .alu_ina   (alu_ina),
        .alu_inb   (alu_inb),
        .alu_out   (alu_out)
    );

    // Behavioural ALU standing in for the real execute-stage ALU.
    function automatic logic [31:0] alu_model(input logic [3:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return a + b;
            4'h3:    return a ^ b;
            4'h4:    return a << b[4:0];
            4'h5:    return a >> b[4:0];
            4'h6:    return a - b;
            4'h7:    return {31'b0, ($signed(a) < $signed(b))};
            4'h8:    return {31'b0, (a < b)};
            4'h9:    return ~(a | b);
            default: return 32'hBAD0_0BAD;
        endcase
    endfunction

    assign alu_out = alu_model(alu_op, alu_ina, alu_inb);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_port(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            req_op0 = op; req_a0 = a; req_b0 = b;
        end else begin
            req_op1 = op; req_a1 = a; req_b1 = b;
        end
    endtask

    // Queue the response the DUT owes for a request accepted this cycle.
    task automatic push_exp(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.port = p;
        e.acc  = cyc;
        if (op <= 4'h9) begin
            e.data = alu_model(op, a, b);
            e.zero = (e.data == 32'd0);
            e.err  = 1'b0;
            e.lat  = 2;
            last_legal_op = op;
        end else begin
            e.data = 32'd0;
            e.zero = 1'b1;
            e.err  = 1'b1;
            e.lat  = 1;
        end
        sb.push_back(e);
    endtask

    // Drive one request on a single port, wait (bounded) for its grant.
    // Returns in the drive phase of the cycle after the handshake edge.
    task automatic issue(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        set_port(p, op, a, b);
        req_valid[p] = 1'b1;
        forever begin
            @(negedge clk);
            if (req_ready[p]) begin
                push_exp(p, op, a, b);
                break;
            end
            if (n == 40) begin
                check_eq("grant_timeout", 64'd0, 64'd1);
                break;
            end
            n++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        set_port(p, ~op, ~a, a ^ b);
        exp_ptr = (p == 0);
    endtask

    // Compares each new response against the scoreboard, then checks that
    // the response stays stable while back-pressured.
    task automatic monitor_loop();
        bit          seen;
        logic [33:0] hold;
        exp_t        e;
        seen = 1'b0;
        hold = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                seen = 1'b0;
            end else if (rsp_valid != 2'b00) begin
                if (!seen) begin
                    seen = 1'b1;
                    hold = {rsp_err, rsp_zero, rsp_data};
                    if (sb.size() == 0) begin
                        check_eq("unexpected_rsp", 64'(rsp_valid), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("rsp_valid",   64'(rsp_valid), 64'(2'b01 << e.port));
                        check_eq("rsp_data",    64'(rsp_data),  64'(e.data));
                        check_eq("rsp_zero",    64'(rsp_zero),  64'(e.zero));
                        check_eq("rsp_err",     64'(rsp_err),   64'(e.err));
                        check_eq("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
                    end
                end else begin
                    check_eq("rsp_hold", 64'({rsp_err, rsp_zero, rsp_data}), 64'(hold));
                end
            end else begin
                seen = 1'b0;
            end
        end
    endtask

    initial begin
        logic [3:0]  cop [2];
        logic [31:0] ca  [2];
        logic [31:0] cb  [2];
        int          g, n, exp_p, p;
        logic [3:0]  op;

        n_checks = 0; n_fail = 0; cyc = 0;
        exp_ptr = 1'b0; last_legal_op = 4'h0;
        reset = 1'b1;
        req_valid = 2'b00; rsp_ready = 2'b11;
        set_port(0, 4'h0, 32'd0, 32'd0);
        set_port(1, 4'h0, 32'd0, 32'd0);

        fork
            monitor_loop();
        join_none

        // ---- reset state --------------------------------------------------
        repeat (2) @(negedge clk);
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_data",  64'(rsp_data),  64'd0);
        check_eq("rst_rsp_zero",  64'(rsp_zero),  64'd0);
        check_eq("rst_rsp_err",   64'(rsp_err),   64'd0);
        check_eq("rst_alu_op",    64'(alu_op),    64'd0);
        check_eq("rst_alu_ina",   64'(alu_ina),   64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // ---- add on port 0: 5 + 7 ----------------------------------------
        issue(0, 4'h2, 32'd5, 32'd7);
        repeat (3) @(posedge clk);
        #1;

        // ---- reset asserted mid-EXEC --------------------------------------
        issue(1, 4'h2, 32'd1, 32'd1);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check_eq("midrst_req_ready", 64'(req_ready), 64'd0);
        check_eq("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_ptr = 1'b0;
        last_legal_op = 4'h0;
        @(negedge clk);
        check_eq("midrst_rsp_data", 64'(rsp_data),  64'd0);
        check_eq("midrst_rsp_zero", 64'(rsp_zero),  64'd0);
        check_eq("midrst_rsp_err",  64'(rsp_err),   64'd0);
        check_eq("midrst_quiet",    64'(rsp_valid), 64'd0);
        @(posedge clk); #1;

        // ---- subtract-to-zero on port 1 -----------------------------------
        issue(1, 4'h6, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // ---- contention: both ports valid for 4 grants --------------------
        for (int i = 0; i < 2; i++) begin
            cop[i] = 4'($urandom_range(0, 9));
            ca[i]  = $urandom;
            cb[i]  = $urandom;
            set_port(i, cop[i], ca[i], cb[i]);
        end
        req_valid = 2'b11;
        g = 0; n = 0;
        while (g < 4 && n < 60) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
`ifdef ALU_RR_ARB_EN
                exp_p = int'(exp_ptr);
`else
                exp_p = 0;
`endif
                check_eq("grant_order", 64'(req_ready), 64'(2'b01 << exp_p));
                push_exp(exp_p, cop[exp_p], ca[exp_p], cb[exp_p]);
                exp_ptr = (exp_p == 0);
                g++;
                @(posedge clk); #1;
                cop[exp_p] = 4'($urandom_range(0, 9));
                ca[exp_p]  = $urandom;
                cb[exp_p]  = $urandom;
                set_port(exp_p, cop[exp_p], ca[exp_p], cb[exp_p]);
            end else begin
                @(posedge clk); #1;
            end
            n++;
        end
        if (g < 4) check_eq("contention_timeout", 64'(g), 64'd4);
        req_valid = 2'b00;

        // ---- back-pressure on port 0, port 1 drops an ungranted request ---
        issue(0, 4'h3, 32'hA5A5_0F0F, 32'h0FF0_1234);
        rsp_ready = 2'b10;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                set_port(1, 4'h2, 32'd1, 32'd2);
                req_valid[1] = 1'b1;
            end
            if (k == 3) req_valid[1] = 1'b0;
            @(negedge clk);
            check_eq("bp_req_ready", 64'(req_ready), 64'd0);
            check_eq("bp_rsp_valid", 64'(rsp_valid), 64'(2'b01));
        end
        @(posedge clk); #1;
        set_port(0, 4'h2, 32'd100, 32'd23);
        req_valid[0] = 1'b1;
        rsp_ready    = 2'b11;
        @(negedge clk);
        check_eq("bp_still_busy", 64'(req_ready), 64'd0);
        @(negedge clk);
        check_eq("bp_resume", 64'(req_ready), 64'(2'b01));
        push_exp(0, 4'h2, 32'd100, 32'd23);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        exp_ptr = 1'b1;

        // ---- illegal opcode on port 0 -------------------------------------
        issue(0, 4'hC, 32'h1234_5678, 32'h0000_0001);
        @(negedge clk);
        check_eq("illegal_alu_op", 64'(alu_op), 64'(last_legal_op));
        @(posedge clk); #1;

        // ---- mixed traffic ------------------------------------------------
        for (int k = 0; k < 6; k++) begin
            p  = int'($urandom_range(0, 1));
            op = (k == 3) ? 4'hF : 4'($urandom_range(0, 9));
            issue(p, op, $urandom, $urandom);
        end

        // ---- drain --------------------------------------------------------
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 64'(sb.size()), 64'd0);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
